// File: rtl/otbn_pq_wb_merge_if.sv
// otbn_pq_wb_merge_if: ALU beat input and merged writeback output bundle.
interface otbn_pq_wb_merge_if #(
  parameter int PQLEN = 32,
  parameter int WLEN  = 256
);
  localparam int NLANES = WLEN / PQLEN;
  logic              valid_i;
  logic              ready_o;
  logic              dual_i;
  logic [WLEN-1:0]   rs0_i;
  logic [WLEN-1:0]   rs1_i;
  logic [WLEN-1:0]   rd_i;
  logic [2:0]        lane_a_i;
  logic [2:0]        lane_b_i;
  logic [2:0]        lane_d_i;
  logic              flush_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [WLEN-1:0]   wdata_a_o;
  logic [WLEN-1:0]   wdata_b_o;
  logic [NLANES-1:0] wen_a_o;
  logic [NLANES-1:0] wen_b_o;
  logic              dual_o;
  modport slave (
    input  valid_i, dual_i, rs0_i, rs1_i, rd_i, lane_a_i, lane_b_i, lane_d_i, flush_i, wb_ready_i,
    output ready_o, wb_valid_o, wdata_a_o, wdata_b_o, wen_a_o, wen_b_o, dual_o
  );
  modport master (
    output valid_i, dual_i, rs0_i, rs1_i, rd_i, lane_a_i, lane_b_i, lane_d_i, flush_i, wb_ready_i,
    input  ready_o, wb_valid_o, wdata_a_o, wdata_b_o, wen_a_o, wen_b_o, dual_o
  );
endinterface

// File: rtl/otbn_pq_wb_merge.sv
// otbn_pq_wb_merge: merges per-lane ALU results into full WDR writebacks.
module otbn_pq_wb_merge #(
  parameter int PQLEN = 32,
  parameter int WLEN  = 256
) (
  input logic clk_i,
  input logic rst_i,
  otbn_pq_wb_merge_if.slave bus
);
  localparam int NLANES = WLEN / PQLEN;
  typedef enum logic [1:0] {EMPTY, FILL, DRAIN} state_e;
  state_e state, state_n;
  logic [WLEN-1:0] buf_a, buf_b, buf_a_n, buf_b_n, src_a;
  logic [NLANES-1:0] mask_a, mask_b, mask_a_n, mask_b_n;
  logic [2:0] sel_a;
  logic mode, mode_n, ready, acc, full;
  // a mode change stalls the beat on dual_i/mode only, never on valid_i
  assign ready = state == EMPTY || (state == FILL && bus.dual_i == mode);
  assign acc   = bus.valid_i && ready;
  assign src_a = bus.dual_i ? bus.rs0_i : bus.rd_i;
  assign sel_a = bus.dual_i ? bus.lane_a_i : bus.lane_d_i;
  always_comb begin
    buf_a_n  = buf_a;
    buf_b_n  = buf_b;
    mask_a_n = mask_a;
    mask_b_n = mask_b;
    mode_n   = (state == EMPTY && acc) ? bus.dual_i : mode;
    state_n  = state;
    for (int i = 0; i < NLANES; i++) begin
      if (acc && sel_a == 3'(i)) begin
        buf_a_n[i*PQLEN +: PQLEN] = src_a[i*PQLEN +: PQLEN];
        mask_a_n[i] = 1'b1;
      end
      if (acc && bus.dual_i && bus.lane_b_i == 3'(i)) begin
        buf_b_n[i*PQLEN +: PQLEN] = bus.rs1_i[i*PQLEN +: PQLEN];
        mask_b_n[i] = 1'b1;
      end
    end
    full = &mask_a_n && (!mode_n || &mask_b_n);
    case (state)
      EMPTY: state_n = acc ? ((bus.flush_i || full) ? DRAIN : FILL) : EMPTY;
      FILL:  state_n = (bus.flush_i || full || (bus.valid_i && !ready)) ? DRAIN : FILL;
      default: begin
        if (bus.wb_ready_i) begin
          state_n  = EMPTY;
          buf_a_n  = '0;
          buf_b_n  = '0;
          mask_a_n = '0;
          mask_b_n = '0;
          mode_n   = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= EMPTY;
      buf_a  <= '0;
      buf_b  <= '0;
      mask_a <= '0;
      mask_b <= '0;
      mode   <= 1'b0;
    end else begin
      state  <= state_n;
      buf_a  <= buf_a_n;
      buf_b  <= buf_b_n;
      mask_a <= mask_a_n;
      mask_b <= mask_b_n;
      mode   <= mode_n;
    end
  end
  assign bus.ready_o    = ready;
  assign bus.wb_valid_o = state == DRAIN;
  assign bus.wdata_a_o  = buf_a;
  assign bus.wdata_b_o  = buf_b;
  assign bus.wen_a_o    = mask_a;
  assign bus.wen_b_o    = mask_b;
  assign bus.dual_o     = mode;
endmodule

// File: tb/tb_otbn_pq_wb_merge.sv
// tb_otbn_pq_wb_merge: directed self-checking bench for the writeback merger.
module tb_otbn_pq_wb_merge;
  logic clk = 0;
  logic rst = 1;
  int tests = 0;
  int fails = 0;
  logic [255:0] exp_a, exp_b, hold;
  otbn_pq_wb_merge_if #(.PQLEN(32), .WLEN(256)) bus ();
  otbn_pq_wb_merge #(.PQLEN(32), .WLEN(256)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic d, input int la, input int lb, input int ld,
                      input logic [31:0] va, input logic [31:0] vb, input logic fl);
    bus.valid_i  = 1;
    bus.dual_i   = d;
    bus.lane_a_i = la[2:0];
    bus.lane_b_i = lb[2:0];
    bus.lane_d_i = ld[2:0];
    bus.rs0_i    = {8{32'hDEADBEEF}};
    bus.rs1_i    = {8{32'hCAFEF00D}};
    bus.rd_i     = {8{32'h5A5A5A5A}};
    bus.rs0_i[la*32 +: 32] = va;
    bus.rs1_i[lb*32 +: 32] = vb;
    bus.rd_i[ld*32 +: 32]  = va;
    bus.flush_i  = fl;
    tick;
    bus.valid_i  = 0;
    bus.flush_i  = 0;
  endtask
  task automatic flush;
    bus.flush_i = 1;
    tick;
    bus.flush_i = 0;
  endtask
  task automatic drain(input string tag);
    bus.wb_ready_i = 1;
    tick;
    bus.wb_ready_i = 0;
    chk({tag, "_done_valid"}, bus.wb_valid_o, 0);
    chk({tag, "_done_wen"}, bus.wen_a_o, 0);
  endtask
  initial begin
    bus.valid_i = 0; bus.dual_i = 0; bus.flush_i = 0; bus.wb_ready_i = 0;
    bus.rs0_i = '0; bus.rs1_i = '0; bus.rd_i = '0;
    bus.lane_a_i = 0; bus.lane_b_i = 0; bus.lane_d_i = 0;
    #12;
    chk("rst_wb_valid", bus.wb_valid_o, 0);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_wen_a", bus.wen_a_o, 0);
    chk("rst_wdata_a", bus.wdata_a_o, 0);
    chk("rst_dual", bus.dual_o, 0);
    rst = 0;
    tick;
    // eight single beats fill the word
    exp_a = '0;
    for (int k = 0; k < 8; k++) begin
      exp_a[k*32 +: 32] = 32'h1000_0000 | k;
      beat(0, 0, 0, k, 32'h1000_0000 | k, 0, 0);
      if (k == 6) chk("single_not_yet", bus.wb_valid_o, 0);
    end
    chk("single_wb_valid", bus.wb_valid_o, 1);
    chk("single_wen_a", bus.wen_a_o, 8'hFF);
    chk("single_wdata_a", bus.wdata_a_o, exp_a);
    chk("single_dual", bus.dual_o, 0);
    chk("single_ready", bus.ready_o, 0);
    drain("single");
    // four dual beats on even lanes then flush
    for (int k = 0; k < 8; k += 2) beat(1, k, k, 0, 32'hA, 32'hB, 0);
    chk("dual_partial", bus.wb_valid_o, 0);
    flush;
    exp_a = '0; exp_b = '0;
    for (int k = 0; k < 8; k += 2) begin
      exp_a[k*32 +: 32] = 32'hA;
      exp_b[k*32 +: 32] = 32'hB;
    end
    chk("dual_wb_valid", bus.wb_valid_o, 1);
    chk("dual_wen_a", bus.wen_a_o, 8'h55);
    chk("dual_wen_b", bus.wen_b_o, 8'h55);
    chk("dual_wdata_a", bus.wdata_a_o, exp_a);
    chk("dual_wdata_b", bus.wdata_b_o, exp_b);
    chk("dual_dual", bus.dual_o, 1);
    drain("dual");
    // lane rewrite, then stall five cycles in DRAIN
    beat(0, 0, 0, 3, 32'h1, 0, 0);
    beat(0, 0, 0, 3, 32'h2, 0, 0);
    flush;
    exp_a = '0; exp_a[96 +: 32] = 32'h2;
    chk("rewrite_wen_a", bus.wen_a_o, 8'h08);
    chk("rewrite_wdata_a", bus.wdata_a_o, exp_a);
    hold = bus.wdata_a_o;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("stall_valid", bus.wb_valid_o, 1);
      chk("stall_ready", bus.ready_o, 0);
      chk("stall_wdata", bus.wdata_a_o, hold);
      chk("stall_wen", bus.wen_a_o, 8'h08);
    end
    drain("stall");
    chk("stall_ready_after", bus.ready_o, 1);
    // mode change while filling forces a drain first
    beat(0, 0, 0, 1, 32'h5, 0, 0);
    bus.valid_i = 1; bus.dual_i = 1; bus.lane_a_i = 0; bus.lane_b_i = 0;
    bus.rs0_i = 256'h7; bus.rs1_i = 256'h8;
    #1;
    chk("mode_ready_low", bus.ready_o, 0);
    tick;
    chk("mode_drain_valid", bus.wb_valid_o, 1);
    chk("mode_drain_wen", bus.wen_a_o, 8'h02);
    chk("mode_drain_dual", bus.dual_o, 0);
    bus.wb_ready_i = 1;
    tick;
    bus.wb_ready_i = 0;
    chk("mode_empty", bus.wb_valid_o, 0);
    chk("mode_ready_high", bus.ready_o, 1);
    tick;
    bus.valid_i = 0;
    flush;
    chk("mode_dual_valid", bus.wb_valid_o, 1);
    chk("mode_dual_dual", bus.dual_o, 1);
    chk("mode_dual_wen_a", bus.wen_a_o, 8'h01);
    chk("mode_dual_wen_b", bus.wen_b_o, 8'h01);
    chk("mode_dual_wdata_a", bus.wdata_a_o, 256'h7);
    chk("mode_dual_wdata_b", bus.wdata_b_o, 256'h8);
    drain("mode");
    // beat and flush together
    beat(0, 0, 0, 5, 32'h99, 0, 1);
    exp_a = '0; exp_a[160 +: 32] = 32'h99;
    chk("bflush_valid", bus.wb_valid_o, 1);
    chk("bflush_wen", bus.wen_a_o, 8'h20);
    chk("bflush_wdata", bus.wdata_a_o, exp_a);
    drain("bflush");
    // flush with an empty buffer is ignored
    flush;
    chk("empty_flush", bus.wb_valid_o, 0);
    // reset mid-fill discards the buffer
    beat(0, 0, 0, 0, 32'h11, 0, 0);
    beat(0, 0, 0, 1, 32'h22, 0, 0);
    beat(0, 0, 0, 2, 32'h33, 0, 0);
    rst = 1;
    #2;
    chk("midrst_wen", bus.wen_a_o, 0);
    chk("midrst_valid", bus.wb_valid_o, 0);
    chk("midrst_ready", bus.ready_o, 1);
    #3;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("postrst_valid", bus.wb_valid_o, 0);
    end
    flush;
    chk("postrst_flush", bus.wb_valid_o, 0);
    chk("postrst_wen", bus.wen_a_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
